spi_byte_sequencer: RTL and testbench

Byte-queue front end that sits directly upstream of the SPI master and feeds its `din_i`/`start_i` inputs, consuming its `dout_o`/`spi_done_tick_o`/`ready_o` outputs. It accepts transmit bytes into a TX FIFO and launches one SPI master transfer per byte. It captures each received byte into an RX FIFO. Transfers are issued only when the RX FIFO can take the result, so no received byte is ever lost.

---
 rtl/spi_byte_sequencer.sv | 127 ++++++++++++
 tb/tb_spi_byte_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_sequencer.sv
// Byte-queue front end for an SPI master: TX FIFO feeding one transfer per
// byte, RX FIFO capturing each received byte. A transfer is launched only
// when the RX FIFO has room, so a received byte always has a slot.
module spi_byte_sequencer #(
  parameter int FIFO_DEPTH = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [7:0]    tx_data_i,
  input  logic          tx_valid_i,
  output logic          tx_ready_o,
  output logic [7:0]    rx_data_o,
  output logic          rx_valid_o,
  input  logic          rx_ready_i,
  output logic [LW-1:0] tx_level_o,
  output logic [LW-1:0] rx_level_o,
  output logic          busy_o,
  output logic [7:0]    spi_din_o,
  output logic          spi_start_o,
  input  logic          spi_ready_i,
  input  logic          spi_done_tick_i,
  input  logic [7:0]    spi_dout_i
);

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] ONE = LW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]    state_reg;
  logic [7:0]    din_reg;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [LW-1:0] tx_wr_reg, tx_rd_reg, tx_count_reg;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [LW-1:0] rx_wr_reg, rx_rd_reg, rx_count_reg;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, launch, rx_push, rx_pop;

  // Pointer MSB differs only when the write side has wrapped once more than read.
  assign tx_empty = (tx_wr_reg == tx_rd_reg);
  assign tx_full  = (tx_wr_reg[LW-1] != tx_rd_reg[LW-1]) &&
                    (tx_wr_reg[AW-1:0] == tx_rd_reg[AW-1:0]);
  assign rx_empty = (rx_wr_reg == rx_rd_reg);
  assign rx_full  = (rx_wr_reg[LW-1] != rx_rd_reg[LW-1]) &&
                    (rx_wr_reg[AW-1:0] == rx_rd_reg[AW-1:0]);

  assign tx_ready_o = !rst_i && !tx_full;
  assign tx_push    = tx_valid_i && tx_ready_o && !flush_i;
  assign launch     = (state_reg == ST_IDLE) && !tx_empty && !rx_full && spi_ready_i;
  assign rx_push    = (state_reg == ST_WAIT) && spi_done_tick_i;
  assign rx_pop     = !rx_empty && rx_ready_i && !flush_i;

  assign rx_valid_o  = !rx_empty;
  assign rx_data_o   = rx_empty ? 8'h00 : rx_mem[rx_rd_reg[AW-1:0]];
  assign tx_level_o  = tx_count_reg;
  assign rx_level_o  = rx_count_reg;
  assign spi_din_o   = din_reg;
  assign spi_start_o = (state_reg == ST_START);
  assign busy_o      = (state_reg != ST_IDLE) || (tx_count_reg != '0);

  // TX storage write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_reg[AW-1:0]] <= tx_data_i;
  end

  // TX pointers and occupancy; the launch pop is applied before a flush clears the rest.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      tx_wr_reg    <= '0;
      tx_rd_reg    <= '0;
      tx_count_reg <= '0;
    end else begin
      if (tx_push) tx_wr_reg <= tx_wr_reg + ONE;
      if (launch)  tx_rd_reg <= tx_rd_reg + ONE;
      tx_count_reg <= tx_count_reg + (tx_push ? ONE : '0) - (launch ? ONE : '0);
    end
  end

  // RX storage write; a byte finishing during a flush lands in slot 0 of the emptied FIFO.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[flush_i ? '0 : rx_wr_reg[AW-1:0]] <= spi_dout_i;
  end

  // RX pointers and occupancy; a completing transfer survives a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_wr_reg    <= '0;
      rx_rd_reg    <= '0;
      rx_count_reg <= '0;
    end else if (flush_i) begin
      rx_rd_reg    <= '0;
      rx_wr_reg    <= rx_push ? ONE : '0;
      rx_count_reg <= rx_push ? ONE : '0;
    end else begin
      if (rx_push) rx_wr_reg <= rx_wr_reg + ONE;
      if (rx_pop)  rx_rd_reg <= rx_rd_reg + ONE;
      rx_count_reg <= rx_count_reg + (rx_push ? ONE : '0) - (rx_pop ? ONE : '0);
    end
  end

  // Transfer sequencer: launch one byte, pulse start for a cycle, wait for done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      din_reg   <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            state_reg <= ST_START;
            din_reg   <= tx_mem[tx_rd_reg[AW-1:0]];
          end
        end
        ST_START: state_reg <= ST_WAIT;
        ST_WAIT:  if (spi_done_tick_i) state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: a simple SPI master model answers each start
// with (din ^ 8'h99) after a programmable latency; a queue-based reference
// model predicts every output each cycle, plus directed literal checks.
module tb_spi_byte_sequencer;
  localparam int D  = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i = 1'b1, flush_i = 1'b0, tx_valid_i = 1'b0, rx_ready_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       ready_en = 1'b0, m_busy = 1'b0, m_done = 1'b0, inj_done = 1'b0;
  logic [7:0] m_dout = 8'h00, inj_dout = 8'h00, m_byte = 8'h00;
  int         lat = 2;

  wire       spi_ready_i     = ready_en && !m_busy;
  wire       spi_done_tick_i = m_done || inj_done;
  wire [7:0] spi_dout_i      = inj_done ? inj_dout : m_dout;

  logic          tx_ready_o, rx_valid_o, busy_o, spi_start_o;
  logic [7:0]    rx_data_o, spi_din_o;
  logic [LW-1:0] tx_level_o, rx_level_o;

  spi_byte_sequencer #(.FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_level_o(tx_level_o), .rx_level_o(rx_level_o), .busy_o(busy_o),
    .spi_din_o(spi_din_o), .spi_start_o(spi_start_o), .spi_ready_i(spi_ready_i),
    .spi_done_tick_i(spi_done_tick_i), .spi_dout_i(spi_dout_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Master model: sees start, waits lat cycles, then pulses done for one cycle.
  always begin
    @(posedge clk); #1;
    if (spi_start_o && !m_busy) begin
      m_busy = 1'b1;
      m_byte = spi_din_o ^ 8'h99;
      repeat (lat) @(posedge clk);
      #1;
      m_done = 1'b1;
      m_dout = m_byte;
      @(posedge clk); #1;
      m_done = 1'b0;
      m_busy = 1'b0;
    end
  end

  // Reference model: queues for the FIFOs, a phase number for the transfer.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int         phase = 0;     // 0 none in flight, 1 start pulse cycle, 2 awaiting done
  logic [7:0] exp_din = 8'h00;
  bit         mvalid = 1'b0;
  bit         tpush, rpop, go, got;

  always @(posedge clk) begin
    if (rst_i) begin
      txq.delete(); rxq.delete();
      phase = 0; exp_din = 8'h00; mvalid = 1'b1;
    end else begin
      tpush = tx_valid_i && (txq.size() < D) && !flush_i;
      rpop  = (rxq.size() > 0) && rx_ready_i && !flush_i;
      go    = (phase == 0) && (txq.size() > 0) && (rxq.size() < D) && spi_ready_i;
      got   = (phase == 2) && spi_done_tick_i;
      if (go) exp_din = txq.pop_front();
      if (rpop) void'(rxq.pop_front());
      if (flush_i) begin txq.delete(); rxq.delete(); end
      if (tpush) txq.push_back(tx_data_i);
      if (got) rxq.push_back(spi_dout_i);
      if (go) phase = 1;
      else if (phase == 1) phase = 2;
      else if (got) phase = 0;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("tx_level", 32'(tx_level_o), 32'(txq.size()));
      chk("rx_level", 32'(rx_level_o), 32'(rxq.size()));
      chk("rx_valid", 32'(rx_valid_o), 32'(rxq.size() != 0));
      chk("rx_data", 32'(rx_data_o), (rxq.size() != 0) ? 32'(rxq[0]) : 32'h0);
      chk("tx_ready", 32'(tx_ready_o), 32'(!rst_i && (txq.size() < D)));
      chk("busy", 32'(busy_o), 32'((phase != 0) || (txq.size() != 0)));
      chk("spi_start", 32'(spi_start_o), 32'(phase == 1));
      chk("spi_din", 32'(spi_din_o), 32'(exp_din));
    end
  end

  // Log of bytes presented with each start pulse.
  logic [7:0] start_log[$];
  always @(negedge clk) begin
    if (mvalid && spi_start_o) start_log.push_back(spi_din_o);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(logic [7:0] d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    cyc(1);
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(int lim);
    int k = 0;
    while ((m_busy || busy_o) && k < lim) begin cyc(1); k++; end
    chk("idle_timeout", 32'(k < lim), 32'd1);
  endtask

  task automatic wait_starts(int target, int lim);
    int k = 0;
    while (start_log.size() < target && k < lim) begin cyc(1); k++; end
    chk("start_timeout", 32'(start_log.size() >= target), 32'd1);
  endtask

  task automatic do_reset();
    int k = 0;
    while (m_busy && k < 200) begin cyc(1); k++; end
    chk("master_idle_timeout", 32'(!m_busy), 32'd1);
    flush_i = 1'b0; tx_valid_i = 1'b0; rx_ready_i = 1'b0; ready_en = 1'b0;
    rst_i = 1'b1;
    cyc(2);
    rst_i = 1'b0;
    cyc(1);
  endtask

  int base;

  initial begin
    cyc(1);
    do_reset();
    chk("rst_tx_level", 32'(tx_level_o), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(rx_data_o), 32'h0);
    chk("rst_spi_din", 32'(spi_din_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready_o), 32'd1);

    // Single byte with latency pinned by hand.
    lat = 16; ready_en = 1'b1; base = start_log.size();
    write_byte(8'hA5);
    chk("lat_tx_level", 32'(tx_level_o), 32'd1);
    chk("lat_no_start", 32'(spi_start_o), 32'd0);
    cyc(1);
    chk("lat_start", 32'(spi_start_o), 32'd1);
    chk("lat_din", 32'(spi_din_o), 32'hA5);
    wait_idle(100);
    cyc(2);
    chk("single_starts", 32'(start_log.size() - base), 32'd1);
    chk("single_din", 32'(spi_din_o), 32'hA5);
    chk("single_rx_valid", 32'(rx_valid_o), 32'd1);
    chk("single_rx_data", 32'(rx_data_o), 32'h3C);
    chk("single_rx_level", 32'(rx_level_o), 32'd1);
    $display("single byte: sent a5, received %h", rx_data_o);

    // Fill TX with master not ready, then release.
    do_reset();
    lat = 2; rx_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    chk("fill_tx_ready", 32'(tx_ready_o), 32'd0);
    chk("fill_tx_level", 32'(tx_level_o), 32'd8);
    write_byte(8'h09);
    chk("fill_refused", 32'(tx_level_o), 32'd8);
    base = start_log.size();
    ready_en = 1'b1;
    wait_starts(base + 8, 300);
    wait_idle(100);
    cyc(5);
    chk("fill_starts", 32'(start_log.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < start_log.size())
        chk("fill_order", 32'(start_log[base + i]), 32'(i + 1));
    end
    $display("fill tx: %0d starts issued", start_log.size() - base);

    // RX backpressure: 10 bytes, RX holds 8.
    do_reset();
    lat = 2; ready_en = 1'b1; base = start_log.size();
    for (int i = 0; i < 10; i++) write_byte(8'h10 + 8'(i));
    wait_starts(base + 8, 300);
    cyc(30);
    chk("bp_starts", 32'(start_log.size() - base), 32'd8);
    chk("bp_tx_level", 32'(tx_level_o), 32'd2);
    chk("bp_rx_level", 32'(rx_level_o), 32'd8);
    chk("bp_hold", 32'(spi_start_o), 32'd0);
    rx_ready_i = 1'b1;
    cyc(1);
    rx_ready_i = 1'b0;
    cyc(2);
    chk("bp_ninth_start", 32'(start_log.size() - base), 32'd9);
    rx_ready_i = 1'b1;
    wait_idle(300);
    cyc(3);
    rx_ready_i = 1'b0;
    chk("bp_drained", 32'(rx_level_o), 32'd0);
    $display("rx backpressure: %0d starts total", start_log.size() - base);

    // Simultaneous RX push and pop at level 7.
    do_reset();
    lat = 3; ready_en = 1'b1;
    for (int i = 0; i < 7; i++) write_byte(8'h40 + 8'(i));
    wait_idle(300);
    chk("sim_pre_level", 32'(rx_level_o), 32'd7);
    write_byte(8'h47);
    begin
      int k = 0;
      while (k < 60) begin
        cyc(1); #1;
        if (spi_done_tick_i) break;
        k++;
      end
      chk("sim_done_timeout", 32'(k < 60), 32'd1);
    end
    rx_ready_i = 1'b1;
    cyc(1);
    rx_ready_i = 1'b0;
    chk("sim_level", 32'(rx_level_o), 32'd7);
    chk("sim_head", 32'(rx_data_o), 32'hD8);
    rx_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("sim_order", 32'(rx_data_o), 32'((8'h41 + 8'(i)) ^ 8'h99));
      cyc(1);
    end
    rx_ready_i = 1'b0;
    chk("sim_empty", 32'(rx_valid_o), 32'd0);
    $display("simultaneous push/pop: order verified");

    // Flush while the first of four bytes is in flight.
    do_reset();
    lat = 10; ready_en = 1'b1; base = start_log.size();
    for (int i = 0; i < 4; i++) write_byte(8'h81 + 8'(i));
    chk("flush_pre_level", 32'(tx_level_o), 32'd3);
    flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    chk("flush_tx_level", 32'(tx_level_o), 32'd0);
    chk("flush_busy", 32'(busy_o), 32'd1);
    wait_idle(100);
    cyc(5);
    chk("flush_rx_level", 32'(rx_level_o), 32'd1);
    chk("flush_rx_data", 32'(rx_data_o), 32'h18);
    chk("flush_starts", 32'(start_log.size() - base), 32'd1);
    $display("flush: rx holds %h", rx_data_o);

    // Reset during a transfer, then stray done ticks.
    do_reset();
    lat = 10; ready_en = 1'b1; base = start_log.size();
    write_byte(8'hC3);
    cyc(3);
    rst_i = 1'b1;
    cyc(1);
    chk("rst_mid_tx_ready", 32'(tx_ready_o), 32'd0);
    chk("rst_mid_start", 32'(spi_start_o), 32'd0);
    cyc(1);
    rst_i = 1'b0;
    begin
      int k = 0;
      while (m_busy && k < 100) begin cyc(1); k++; end
      chk("rst_mid_master_timeout", 32'(k < 100), 32'd1);
    end
    cyc(3);
    chk("rst_mid_rx_level", 32'(rx_level_o), 32'd0);
    chk("rst_mid_starts", 32'(start_log.size() - base), 32'd1);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    inj_dout = 8'h55; inj_done = 1'b1;
    cyc(1);
    inj_done = 1'b0;
    cyc(1);
    chk("spurious_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("spurious_rx_level", 32'(rx_level_o), 32'd0);
    $display("reset mid-transfer and stray tick: rx level %0d", rx_level_o);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
